// File: rtl/cin_convert_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cin_convert_ctrl_pkg
//  Description : Shared definitions for the 2:1 channel width converter
//                controller. Holds the picture/channel defaults, the FSM
//                state encoding and the half-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package cin_convert_ctrl_pkg;

    // Defaults shared with the rest of the TJPU output path
    localparam int CCC_PICTURE_NUM = 1;
    localparam int CCC_CH_OUT_NUM  = 16;

    // Width of one output beat for the default configuration
    localparam int H = CCC_PICTURE_NUM * CCC_CH_OUT_NUM * 4;

    // FSM state encoding
    localparam int          CCC_STATE_W = 3;
    localparam logic [2:0]  CCC_IDLE    = 3'd0;
    localparam logic [2:0]  CCC_LOAD    = 3'd1;
    localparam logic [2:0]  CCC_LOW     = 3'd2;
    localparam logic [2:0]  CCC_HIGH    = 3'd3;
    localparam logic [2:0]  CCC_DONE    = 3'd4;

    // Half-width beat size for an arbitrary configuration
    function automatic int ccc_half_width(input int picture_num, input int ch_out_num);
        return picture_num * ch_out_num * 4;
    endfunction

endpackage : cin_convert_ctrl_pkg
`default_nettype wire

// File: rtl/cin_convert_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cin_convert_ctrl
//  Description : Sequencing controller for the 2:1 channel width converter.
//                Accepts full-width words on a valid/ready slave port and
//                emits each as two half-width beats (low half first) on a
//                valid/ready master port. Counts cfg_word_num words per job,
//                flags the final beat with M_Last and pulses done at the end.
//
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                start, cfg_word_num - job start pulse and word count
//                cfg_half_only       - (CIN_CONV_HALF_ONLY_EN only) emit low
//                                      beats only, latched with start
//                busy, done          - job status
//                S_Feature/S_Valid/S_Ready         - full-width slave port
//                M_Feature/M_Valid/M_Ready/M_Last  - half-width master port
//
//  Options     : CIN_CONV_HALF_ONLY_EN - adds the cfg_half_only input.
//  Revision    : 1.0 - initial release
// ============================================================================
module cin_convert_ctrl
    import cin_convert_ctrl_pkg::*;
#(
    parameter int PICTURE_NUM = CCC_PICTURE_NUM,
    parameter int CH_OUT_NUM  = CCC_CH_OUT_NUM,
    parameter int CNT_W       = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [CNT_W-1:0]                  cfg_word_num,
`ifdef CIN_CONV_HALF_ONLY_EN
    input  logic                              cfg_half_only,
`endif
    output logic                              busy,
    output logic                              done,
    input  logic [PICTURE_NUM*CH_OUT_NUM*8-1:0] S_Feature,
    input  logic                              S_Valid,
    output logic                              S_Ready,
    output logic [PICTURE_NUM*CH_OUT_NUM*4-1:0] M_Feature,
    output logic                              M_Valid,
    input  logic                              M_Ready,
    output logic                              M_Last
);

    localparam int c_HALF_W = ccc_half_width(PICTURE_NUM, CH_OUT_NUM);

    logic [CCC_STATE_W-1:0] r_state;
    logic [2*c_HALF_W-1:0]  r_hold;
    logic [CNT_W-1:0]       r_word_cnt;
    logic [CNT_W-1:0]       r_word_num;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_m_valid;
    logic                   r_m_last;

    logic                   w_half_only;
    logic                   w_last_word;
    logic                   w_advance;
    logic                   w_capture;
    logic [CNT_W-1:0]       w_cnt_inc;

`ifdef CIN_CONV_HALF_ONLY_EN
    logic                   r_half_only;
    assign w_half_only = r_half_only;
`else
    assign w_half_only = 1'b0;
`endif

    assign w_cnt_inc   = r_word_cnt + CNT_W'(1);
    assign w_last_word = (r_word_cnt == r_word_num);

    // The current word's final beat is being handed off this cycle: the high
    // beat normally, or the low beat when only low halves are emitted.
    assign w_advance = M_Ready && ((r_state == CCC_HIGH) ||
                                   (r_state == CCC_LOW && w_half_only));

    // Ready either while waiting for a word, or while the previous word's
    // final beat leaves, which lets words stream with no bubble.
    assign S_Ready   = (r_state == CCC_LOAD) || (w_advance && !w_last_word);
    assign w_capture = S_Valid && S_Ready;

    // Beat select from the hold register; only changes on a handshake, so the
    // output is stable while the master stalls.
    assign M_Feature = (r_state == CCC_HIGH) ? r_hold[2*c_HALF_W-1:c_HALF_W]
                                             : r_hold[c_HALF_W-1:0];
    assign M_Valid   = r_m_valid;
    assign M_Last    = r_m_last;
    assign busy      = r_busy;
    assign done      = r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= CCC_IDLE;
            r_hold     <= '0;
            r_word_cnt <= '0;
            r_word_num <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_m_valid  <= 1'b0;
            r_m_last   <= 1'b0;
`ifdef CIN_CONV_HALF_ONLY_EN
            r_half_only <= 1'b0;
`endif
        end else if (w_capture) begin
            // Slave handshake from LOAD or the pipelined accept
            r_hold     <= S_Feature;
            r_word_cnt <= w_cnt_inc;
            r_m_valid  <= 1'b1;
            r_m_last   <= w_half_only && (w_cnt_inc == r_word_num);
            r_state    <= CCC_LOW;
        end else if (w_advance) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            if (w_last_word) begin
                r_done  <= 1'b1;
                r_state <= CCC_DONE;
            end else begin
                r_state <= CCC_LOAD;
            end
        end else begin
            case (r_state)
                CCC_IDLE: begin
                    if (start) begin
                        r_word_num <= cfg_word_num;
                        r_word_cnt <= '0;
                        r_busy     <= 1'b1;
`ifdef CIN_CONV_HALF_ONLY_EN
                        r_half_only <= cfg_half_only;
`endif
                        if (cfg_word_num == '0) begin
                            r_done  <= 1'b1;
                            r_state <= CCC_DONE;
                        end else begin
                            r_state <= CCC_LOAD;
                        end
                    end
                end
                CCC_LOW: begin
                    // Half-only LOW handoff is covered by w_advance above
                    if (M_Ready) begin
                        r_m_last <= w_last_word;
                        r_state  <= CCC_HIGH;
                    end
                end
                CCC_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= CCC_IDLE;
                end
                default: begin
                    // LOAD waits for a word; HIGH waits for M_Ready
                    r_state <= r_state;
                end
            endcase
        end
    end

endmodule : cin_convert_ctrl
`default_nettype wire

// File: tb/tb_cin_convert_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cin_convert_ctrl
//  Description : Self-checking bench for cin_convert_ctrl (default config:
//                PICTURE_NUM=1, CH_OUT_NUM=16 -> 128-bit words, 64-bit beats).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cin_convert_ctrl;

    localparam int c_FW    = 128;
    localparam int c_HW    = 64;
    localparam int c_CNT_W = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [c_CNT_W-1:0] cfg_word_num;
    logic               cfg_half_only;
    logic               busy;
    logic               done;
    logic [c_FW-1:0]    S_Feature;
    logic               S_Valid;
    logic               S_Ready;
    logic [c_HW-1:0]    M_Feature;
    logic               M_Valid;
    logic               M_Ready;
    logic               M_Last;

    int errors = 0;
    int checks = 0;

    logic [c_FW-1:0] words [0:127];
    int g_first_cyc;
    int g_last_cyc;

    always #5 clk = ~clk;

    cin_convert_ctrl #(
        .PICTURE_NUM (1),
        .CH_OUT_NUM  (16),
        .CNT_W       (c_CNT_W)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_word_num (cfg_word_num),
`ifdef CIN_CONV_HALF_ONLY_EN
        .cfg_half_only(cfg_half_only),
`endif
        .busy         (busy),
        .done         (done),
        .S_Feature    (S_Feature),
        .S_Valid      (S_Valid),
        .S_Ready      (S_Ready),
        .M_Feature    (M_Feature),
        .M_Valid      (M_Valid),
        .M_Ready      (M_Ready),
        .M_Last       (M_Last)
    );

    task automatic check(input string tag, input logic [c_FW-1:0] got, input logic [c_FW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one job of n words. Random valid/ready percentages; optional junk
    // start pulses with junk counts while busy. Ends one cycle after done.
    task automatic run_job(input int n, input int sv_pct, input int mr_pct,
                           input int budget, input bit junk, input bit half);
        int bi, wi, total, lasts, dones, cyc, done_cyc;
        bit fin;
        logic [c_HW-1:0] exp_beat;
        total = half ? n : 2 * n;
        tick();
        start         = 1'b1;
        cfg_word_num  = c_CNT_W'(n);
        cfg_half_only = half;
        S_Valid       = 1'b0;
        M_Ready       = 1'b0;
        tick();
        start = 1'b0;
        cyc = 0; fin = 0; wi = 0; bi = 0; lasts = 0; dones = 0;
        done_cyc = -1; g_first_cyc = -1; g_last_cyc = -1;
        while (!fin && cyc < budget) begin
            S_Valid   = ($urandom_range(99) < sv_pct);
            M_Ready   = ($urandom_range(99) < mr_pct);
            S_Feature = (wi < n) ? words[wi] : '0;
            if (junk) begin
                start        = ($urandom_range(9) == 0);
                cfg_word_num = c_CNT_W'($urandom);
            end
            #3;
            if (S_Valid && S_Ready) wi++;
            if (M_Valid && M_Ready) begin
                if (bi >= total) begin
                    check("extra_beat", bi, total - 1);
                end else begin
                    if (half)
                        exp_beat = words[bi][c_HW-1:0];
                    else
                        exp_beat = (bi % 2 == 0) ? words[bi/2][c_HW-1:0] : words[bi/2][c_FW-1:c_HW];
                    check("beat_data", M_Feature, exp_beat);
                    check("beat_last", M_Last, (bi == total - 1));
                end
                if (M_Last) lasts++;
                if (g_first_cyc < 0) g_first_cyc = cyc;
                g_last_cyc = cyc;
                bi++;
            end
            if (done) begin
                dones++;
                done_cyc = cyc;
                fin = 1;
            end
            tick();
            cyc++;
        end
        start   = 1'b0;
        S_Valid = 1'b0;
        M_Ready = 1'b0;
        if (!fin) check("job_timeout", 0, 1);
        check("beat_count", bi, total);
        check("words_taken", wi, n);
        check("last_count", lasts, (n > 0) ? 1 : 0);
        check("done_count", dones, 1);
        if (n > 0) check("done_after_last", done_cyc, g_last_cyc + 1);
        else       check("done_latency", done_cyc, 0);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cfg_word_num = '0; cfg_half_only = 1'b0;
        S_Feature = '0; S_Valid = 1'b0; M_Ready = 1'b0;

        // ---------------- reset and idle ----------------
        repeat (3) tick();
        rst = 1'b0;
        S_Valid = 1'b1;   // must be ignored while idle
        M_Ready = 1'b1;
        repeat (5) tick();
        check("rst_s_ready", S_Ready, 0);
        check("rst_m_valid", M_Valid, 0);
        check("rst_m_last",  M_Last, 0);
        check("rst_busy",    busy, 0);
        check("rst_done",    done, 0);
        check("rst_m_feat",  M_Feature, 0);
        S_Valid = 1'b0;
        M_Ready = 1'b0;

        // ---------------- zero-word job ----------------
        run_job(0, 100, 100, 20, 0, 0);

        // ---------------- 3 words back-to-back ----------------
        words[0] = 128'hA1A1_A1A1_A1A1_A1A1_A0A0_A0A0_A0A0_A0A0;
        words[1] = 128'hB1B1_B1B1_B1B1_B1B1_B0B0_B0B0_B0B0_B0B0;
        words[2] = 128'hC1C1_C1C1_C1C1_C1C1_C0C0_C0C0_C0C0_C0C0;
        run_job(3, 100, 100, 50, 0, 0);
        check("b2b_first_beat", g_first_cyc, 1);
        check("b2b_span", g_last_cyc - g_first_cyc, 5);

        // ---------------- stall during HIGH beat ----------------
        words[0] = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        words[1] = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0123;
        start = 1'b1; cfg_word_num = 2; S_Valid = 1'b1; S_Feature = words[0]; M_Ready = 1'b0;
        tick();                      // LOAD
        start = 1'b0;
        check("st_load_ready", S_Ready, 1);
        tick();                      // LOW word0
        check("st_low_valid", M_Valid, 1);
        check("st_low_data", M_Feature, 64'h5555_6666_7777_8888);
        S_Feature = words[1];
        #1;
        check("st_low_s_ready", S_Ready, 0);
        M_Ready = 1'b1;
        #1;
        check("st_low_s_ready_mr", S_Ready, 0);
        tick();                      // HIGH word0
        M_Ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("st_hold_data", M_Feature, 64'h1111_2222_3333_4444);
            check("st_hold_valid", M_Valid, 1);
            check("st_hold_s_ready", S_Ready, 0);
            check("st_hold_last", M_Last, 0);
            tick();
        end
        M_Ready = 1'b1;
        #1;
        check("st_pipe_ready", S_Ready, 1);
        tick();                      // LOW word1 via pipelined accept
        S_Valid = 1'b0;
        check("st_w1_low", M_Feature, 64'hDDDD_EEEE_FFFF_0123);
        tick();                      // HIGH word1
        check("st_w1_high", M_Feature, 64'h9999_AAAA_BBBB_CCCC);
        check("st_w1_last", M_Last, 1);
        #1;
        check("st_last_s_ready", S_Ready, 0);
        tick();                      // DONE
        check("st_done", done, 1);
        check("st_done_busy", busy, 1);
        check("st_done_valid", M_Valid, 0);
        M_Ready = 1'b0;
        tick();                      // IDLE
        check("st_idle_done", done, 0);
        check("st_idle_busy", busy, 0);

        // ---------------- random 100-word job ----------------
        for (int i = 0; i < 100; i++)
            words[i] = {$urandom, $urandom, $urandom, $urandom};
        run_job(100, 50, 50, 4000, 1, 0);

        // ---------------- reset mid-job ----------------
        start = 1'b1; cfg_word_num = 5; S_Valid = 1'b1; M_Ready = 1'b1; S_Feature = words[0];
        tick();                      // LOAD
        start = 1'b0;
        repeat (4) tick();           // LOW0 HIGH0 LOW1 HIGH1
        check("rm_pre_valid", M_Valid, 1);
        rst = 1'b1;
        tick();
        check("rm_valid", M_Valid, 0);
        check("rm_busy", busy, 0);
        check("rm_done", done, 0);
        check("rm_s_ready", S_Ready, 0);
        rst = 1'b0;
        repeat (3) begin
            tick();
            check("rm_no_done", done, 0);
            check("rm_no_valid", M_Valid, 0);
        end
        S_Valid = 1'b0; M_Ready = 1'b0;
        words[0] = 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978;
        run_job(1, 100, 100, 30, 0, 0);

`ifdef CIN_CONV_HALF_ONLY_EN
        // ---------------- low-beat-only job ----------------
        for (int i = 0; i < 4; i++)
            words[i] = {$urandom, $urandom, $urandom, $urandom};
        run_job(4, 100, 100, 40, 0, 1);
        for (int i = 0; i < 4; i++)
            words[i] = {$urandom, $urandom, $urandom, $urandom};
        run_job(4, 60, 60, 200, 0, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_cin_convert_ctrl
`default_nettype wire
